// File: rtl/hls_monitor_pkg.sv
// Shared types and constants for the HLS dataflow deadlock monitors.
// Holds the FSM encoding, the per-channel stall info codes and the stall counter width.
package hls_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WATCH   = 2'd1,
    ST_BLOCKED = 2'd2
  } mon_state_t;

  localparam logic [1:0] INFO_RD   = 2'b10;
  localparam logic [1:0] INFO_WR   = 2'b01;
  localparam logic [1:0] INFO_NONE = 2'b00;

  localparam int STALL_W = 32;

endpackage

// File: rtl/hls_monitor_prio_enc.sv
// Lowest-index priority encoder with valid; purely combinational, zero latency.
// No backpressure: idx is 0 and vld is 0 when no request bit is set.
module hls_monitor_prio_enc
  import hls_monitor_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  // Scanning downwards lets the lowest set bit win the last assignment.
  always_comb begin
    idx = '0;
    vld = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/hls_deadlock_monitor_param.sv
// Deadlock monitor for one HLS dataflow region: sticky block after THRESH consecutive stall cycles.
// Latency THRESH cycles from first stall to block; observe-only, never backpressures the region.
module hls_deadlock_monitor_param
  import hls_monitor_pkg::*;
#(
  parameter int NUM_AXIS = 2,
  parameter int NUM_INST = 1,
  parameter int THRESH   = 1024,
  parameter int CNT_W    = $clog2(THRESH + 1),
  parameter int CH_W     = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [NUM_AXIS-1:0]   axis_rd_block,
  input  logic [NUM_AXIS-1:0]   axis_wr_block,
  input  logic [NUM_INST-1:0]   inst_idle_sigs,
  input  logic [NUM_INST-1:0]   inst_block_sigs,
  output logic [2*NUM_AXIS-1:0] axis_block_info,
  output logic                  block,
  output logic [CH_W-1:0]       block_ch,
  output logic                  block_ch_valid,
  output logic [STALL_W-1:0]    stall_cycles
);

  mon_state_t            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [2*NUM_AXIS-1:0] info_q;
  logic [CH_W-1:0]       ch_q;
  logic                  ch_vld_q;
  logic [STALL_W-1:0]    stall_q;

  logic                  cand;
  logic                  go_blk;
  logic [2*NUM_AXIS-1:0] snap;
  logic [CH_W-1:0]       enc_idx;
  logic                  enc_vld;

  // An instance that reports idle while blocked is simply finished, not stuck.
  assign cand = (|axis_rd_block) | (|axis_wr_block) | (|(inst_block_sigs & ~inst_idle_sigs));

  always_comb begin
    snap = '0;
    for (int i = 0; i < NUM_AXIS; i++) begin
      snap[2*i +: 2] = (axis_rd_block[i] ? INFO_RD : INFO_NONE) |
                       (axis_wr_block[i] ? INFO_WR : INFO_NONE);
    end
  end

  hls_monitor_prio_enc #(
    .N     (NUM_AXIS),
    .IDX_W (CH_W)
  ) u_prio_enc (
    .req (axis_rd_block | axis_wr_block),
    .idx (enc_idx),
    .vld (enc_vld)
  );

  always_comb begin
    go_blk = 1'b0;
    if (!clear && enable && cand) begin
      if (state_q == ST_IDLE && THRESH == 1) go_blk = 1'b1;
      if (state_q == ST_WATCH && cnt_q == CNT_W'(THRESH - 1)) go_blk = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      info_q   <= '0;
      ch_q     <= '0;
      ch_vld_q <= 1'b0;
      stall_q  <= '0;
    end else if (clear) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      info_q   <= '0;
      ch_q     <= '0;
      ch_vld_q <= 1'b0;
      stall_q  <= '0;
    end else if (go_blk) begin
      state_q  <= ST_BLOCKED;
      cnt_q    <= '0;
      info_q   <= snap;
      ch_q     <= enc_idx;
      ch_vld_q <= enc_vld;
      stall_q  <= STALL_W'(1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable && cand) begin
            state_q <= ST_WATCH;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        ST_WATCH: begin
          // Any single gap in the stall restarts the persistence count.
          if (enable && cand) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        end
        ST_BLOCKED: begin
          if (stall_q != '1) stall_q <= stall_q + STALL_W'(1);
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign block           = (state_q == ST_BLOCKED);
  assign axis_block_info = info_q;
  assign block_ch        = ch_q;
  assign block_ch_valid  = ch_vld_q;
  assign stall_cycles    = stall_q;

endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// Self-checking bench: directed scenarios plus random stimulus against a run-length reference model.
module tb_hls_deadlock_monitor_param;

  localparam int NA = 2;
  localparam int NI = 1;
  localparam int TH = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic [NA-1:0] rd = '0;
  logic [NA-1:0] wr = '0;
  logic [NI-1:0] ib = '0;
  logic [NI-1:0] ii = '0;

  logic [2*NA-1:0] info;
  logic            blk;
  logic [0:0]      ch;
  logic            chv;
  logic [31:0]     sc;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: a run length of qualifying cycles and a latched report.
  int          run = 0;
  bit          m_blk = 0;
  logic [3:0]  m_info = '0;
  int          m_ch = 0;
  bit          m_chv = 0;
  logic [31:0] m_stall = '0;

  hls_deadlock_monitor_param #(
    .NUM_AXIS (NA),
    .NUM_INST (NI),
    .THRESH   (TH)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .enable          (enable),
    .clear           (clear),
    .axis_rd_block   (rd),
    .axis_wr_block   (wr),
    .inst_idle_sigs  (ii),
    .inst_block_sigs (ib),
    .axis_block_info (info),
    .block           (blk),
    .block_ch        (ch),
    .block_ch_valid  (chv),
    .stall_cycles    (sc)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_zero();
    run = 0; m_blk = 0; m_info = '0; m_ch = 0; m_chv = 0; m_stall = '0;
  endtask

  task automatic model_edge();
    bit cand;
    cand = (|rd) || (|wr) || (|(ib & ~ii));
    if (!reset_n || clear) begin
      model_zero();
    end else if (m_blk) begin
      if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    end else if (enable && cand) begin
      run++;
      if (run == TH) begin
        m_blk = 1; run = 0; m_stall = 1; m_chv = 0; m_ch = 0;
        for (int i = 0; i < NA; i++) begin
          m_info[2*i+1] = rd[i];
          m_info[2*i]   = wr[i];
        end
        for (int i = NA - 1; i >= 0; i--) begin
          if (rd[i] || wr[i]) begin m_ch = i; m_chv = 1; end
        end
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic check_all();
    chk("block", 64'(blk), 64'(m_blk));
    chk("info", 64'(info), 64'(m_info));
    chk("block_ch", 64'(ch), 64'(m_ch));
    chk("block_ch_valid", 64'(chv), 64'(m_chv));
    chk("stall_cycles", 64'(sc), 64'(m_stall));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic b, input logic i_idle,
                       input logic en, input logic clr, input int n);
    rd = r; wr = w; ib = b; ii = i_idle; enable = en; clear = clr;
    for (int k = 0; k < n; k++) step();
    clear = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check_all();
    chk("rst_block", 64'(blk), 64'd0);
    #10 reset_n = 1'b1;
    enable = 1'b1;

    // Persistent write stall on channel 1
    drive(2'b00, 2'b10, 0, 0, 1, 0, 3);
    chk("persist_not_yet", 64'(blk), 64'd0);
    drive(2'b00, 2'b10, 0, 0, 1, 0, 1);
    chk("persist_block", 64'(blk), 64'd1);
    chk("persist_info", 64'(info), 64'h4);
    chk("persist_ch", 64'(ch), 64'd1);
    chk("persist_chv", 64'(chv), 64'd1);
    chk("persist_sc1", 64'(sc), 64'd1);
    drive(2'b00, 2'b00, 0, 0, 1, 0, 2);
    chk("persist_sc3", 64'(sc), 64'd3);
    chk("sticky_info", 64'(info), 64'h4);
    drive(2'b00, 2'b00, 0, 0, 1, 1, 1);
    chk("clear_block", 64'(blk), 64'd0);
    chk("clear_sc", 64'(sc), 64'd0);

    // Glitch rejection
    drive(2'b01, 2'b00, 0, 0, 1, 0, 3);
    drive(2'b00, 2'b00, 0, 0, 1, 0, 1);
    drive(2'b01, 2'b00, 0, 0, 1, 0, 3);
    chk("glitch_block", 64'(blk), 64'd0);
    drive(2'b00, 2'b00, 0, 0, 1, 0, 1);

    // Instance-only stall, then idle-masked instance
    drive(2'b00, 2'b00, 1, 0, 1, 0, 4);
    chk("inst_block", 64'(blk), 64'd1);
    chk("inst_info", 64'(info), 64'h0);
    chk("inst_chv", 64'(chv), 64'd0);
    drive(2'b00, 2'b00, 0, 0, 1, 1, 1);
    drive(2'b00, 2'b00, 1, 1, 1, 0, 6);
    chk("inst_idle_block", 64'(blk), 64'd0);

    // Clear while stall persists restarts detection
    drive(2'b00, 2'b01, 0, 0, 1, 0, 4);
    chk("restall_block", 64'(blk), 64'd1);
    drive(2'b00, 2'b01, 0, 0, 1, 1, 1);
    chk("restall_clear", 64'(blk), 64'd0);
    drive(2'b00, 2'b01, 0, 0, 1, 0, 4);
    chk("restall_again", 64'(blk), 64'd1);
    chk("restall_info", 64'(info), 64'h1);
    drive(2'b00, 2'b00, 0, 0, 1, 1, 1);

    // Enable gating and simultaneous stalls
    drive(2'b11, 2'b00, 0, 0, 0, 0, 10);
    chk("disabled_block", 64'(blk), 64'd0);
    drive(2'b11, 2'b01, 0, 0, 1, 0, 4);
    chk("multi_block", 64'(blk), 64'd1);
    chk("multi_info", 64'(info), 64'hB);
    chk("multi_ch", 64'(ch), 64'd0);

    // Asynchronous reset between edges while blocked
    drive(2'b00, 2'b00, 0, 0, 1, 0, 2);
    rd = '0; wr = '0; ib = '0;
    #3 reset_n = 1'b0;
    #1;
    model_zero();
    check_all();
    chk("async_rst_block", 64'(blk), 64'd0);
    #3 reset_n = 1'b1;
    drive(2'b00, 2'b00, 0, 0, 1, 0, 5);
    chk("post_rst_block", 64'(blk), 64'd0);

    // Random traffic with sticky-ish patterns so that runs reach the threshold
    begin
      logic [1:0] pr, pw;
      logic pb, pi;
      pr = '0; pw = '0; pb = 0; pi = 0;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(0, 5) == 0) begin
          pr = 2'($urandom_range(0, 3)) & {2{$urandom_range(0, 1) == 1}};
          pw = 2'($urandom_range(0, 3)) & {2{$urandom_range(0, 1) == 1}};
          pb = 1'($urandom_range(0, 1));
          pi = 1'($urandom_range(0, 1));
        end
        rd = pr; wr = pw; ib = pb; ii = pi;
        enable = ($urandom_range(0, 15) != 0);
        clear  = ($urandom_range(0, 29) == 0);
        step();
      end
      clear = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hls_deadlock_monitor_param.md
# hls_deadlock_monitor_param

Parametrised deadlock monitor for HLS dataflow regions, the generalised successor of the per-instance idx monitors. It watches N AXI-Stream channels, separately for read-side and write-side stalls, and M sub-instance block/idle pairs. It asserts a sticky `block` only after a stall has persisted for a programmable number of consecutive cycles. At that point it freezes a snapshot of which channels were stalled, reports the lowest stalled channel index, and counts how long the deadlock has lasted. One instance sits beside each dataflow region and feeds the top-level deadlock report.

## Interface
Parameters:
- `NUM_AXIS`, 2: number of monitored AXIS channels (≥1).
- `NUM_INST`, 1: number of monitored sub-instances (≥1).
- `THRESH`, 1024: consecutive stall cycles required before `block` asserts (≥1).
- `CNT_W`, $clog2(THRESH+1): persistence counter width (derived).
- `CH_W`, max(1,$clog2(NUM_AXIS)): channel index width (derived).

Ports:
- `clock`  in  1  sole clock, all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  arms detection; 0 holds the FSM in IDLE unless it is already BLOCKED.
- `clear`  in  1  synchronous clear of the sticky state; priority over all other inputs.
- `axis_rd_block`  in  NUM_AXIS  channel i consumer stalled on an empty stream.
- `axis_wr_block`  in  NUM_AXIS  channel i producer stalled on a full stream.
- `inst_idle_sigs`  in  NUM_INST  sub-instance j idle.
- `inst_block_sigs`  in  NUM_INST  sub-instance j blocked.
- `axis_block_info`  out  2*NUM_AXIS  per-channel snapshot; bits [2i+1:2i] = {rd,wr} of channel i; zero unless `block`.
- `block`  out  1  sticky deadlock flag.
- `block_ch`  out  CH_W  lowest-index stalled channel at detection.
- `block_ch_valid`  out  1  `block_ch` meaningful, i.e. at least one channel was stalled at detection.
- `stall_cycles`  out  32  cycles spent in BLOCKED, saturating at 32'hFFFF_FFFF.

## Operation
- Stall candidate: `cand = |axis_rd_block | |axis_wr_block | |(inst_block_sigs & ~inst_idle_sigs)`. A blocked instance that is also idle does not count.
- FSM states IDLE, WATCH, BLOCKED; counter `cnt` is CNT_W bits.
- IDLE:
  - `enable & cand`: go to BLOCKED if THRESH==1, else go to WATCH with cnt=1.
  - Otherwise stay in IDLE with cnt=0.
- WATCH:
  - `~cand | ~enable`: return to IDLE with cnt=0. Any gap restarts the count.
  - `cand & cnt==THRESH-1`: go to BLOCKED.
  - `cand` otherwise: cnt+1.
- Entry to BLOCKED (the same edge):
  - Capture the snapshot from that edge's inputs, {rd,wr} per channel.
  - `block_ch` = lowest i with rd|wr set. `block_ch_valid` = any channel set.
  - If only an instance stalled, `block_ch_valid`=0 and `block_ch`=0.
  - `stall_cycles` is set to 1.
- BLOCKED is sticky and ignores `cand` and `enable`. `stall_cycles` increments each cycle and saturates. The snapshot is frozen.
- `clear`: on the next edge, go to IDLE and zero cnt, the snapshot, `block_ch`, `block_ch_valid` and `stall_cycles`. If `cand` is still high, detection restarts on the edge after the clear edge.
- Reset (`reset_n`=0, any time including mid-WATCH or mid-BLOCKED): outputs go to 0 immediately.
  - State goes to IDLE, cnt=0.
  - `block`=0, `axis_block_info`=0, `block_ch`=0, `block_ch_valid`=0, `stall_cycles`=0.

## Timing
- All outputs are registered or a direct decode of registered state; there are no combinational input→output paths.
- Latency: with `cand` first high in cycle k and held high, `block` rises in cycle k+THRESH. For THRESH=1 this is one cycle, the legacy behaviour.
- `axis_block_info`, `block_ch` and `block_ch_valid` become valid in the same cycle `block` rises.
- `stall_cycles`=1 in the first cycle `block` is high.
- `clear` asserted in cycle c: `block`=0 in cycle c+1.
- `clear` and `reset_n` deassertion in the same cycle: reset wins while it is asserted.

## Structure
- Shared package `hls_monitor_pkg` holds:
  - the FSM state enum (IDLE/WATCH/BLOCKED, 2 bits);
  - the per-channel info code localparams: RD=2'b10, WR=2'b01, NONE=2'b00;
  - the `stall_cycles` width localparam (32).
- One natural sub-module, `hls_monitor_prio_enc`: a NUM_AXIS-input lowest-index priority encoder with a valid output. It produces `block_ch` and `block_ch_valid` from the rd|wr vector.

## Test plan
Bench parameters: NUM_AXIS=2, NUM_INST=1, THRESH=4.
- Persistent stall: `axis_wr_block`=2'b10 held 4 cycles → `block`=1 at cycle 4, `axis_block_info`=4'b0100, `block_ch`=1, `block_ch_valid`=1, `stall_cycles` reads 1,2,3… on later cycles.
- Glitch rejection: `axis_rd_block`[0] high 3 cycles, low 1 cycle, then high 3 cycles → `block` never asserts and cnt returns to 0 at the gap.
- Instance-only stall: inst_block=1, inst_idle=0 for 4 cycles → `block`=1, `axis_block_info`=0, `block_ch_valid`=0. Repeating with inst_idle=1 → no block.
- Sticky and clear: after block, drop all stall inputs → `block` stays 1 and the snapshot is unchanged. Pulse `clear` → `block`=0 next cycle and `stall_cycles`=0. Then re-stall 4 cycles → block again.
- Enable gating and simultaneous stalls: `enable`=0 with rd=2'b11 for 10 cycles → no block. Raise `enable` with rd=2'b11, wr=2'b01 → after 4 cycles `axis_block_info`=4'b1011, `block_ch`=0.
- Async reset mid-BLOCKED: drop `reset_n` between edges → all outputs 0 without waiting for a clock edge. After release with no stalls → stays in IDLE.
